alu_dispatch: RTL and testbench

- Decode/issue stage that drives the ALU operand and opcode inputs: it takes a fetched RV32I instruction plus register-file read data and produces registered `a`, `b` and `op` values for the ALU.
- Also produces writeback/branch side-band signals.
- Sits between fetch/regfile read and execute, with valid/ready handshakes on both sides.
- Uses a 2-entry skid buffer so `in_ready_o` is a flop output.

---
 rtl/alu_dispatch.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_alu_dispatch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch -- RV32I decode/issue stage feeding the ALU.
//
// Decodes one fetched instruction per cycle together with its register-file
// read data and presents registered ALU operands (a_o, b_o), the ALU opcode
// (op_o) and writeback/branch side-band signals to the execute stage.
// A one-entry output register plus a one-entry skid register let in_ready_o
// come straight from a flop while still sustaining one instruction per cycle.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   flush_i                 synchronous kill of every buffered instruction
//   in_valid_i/in_ready_o   upstream handshake
//   instr_i, pc_i           instruction word and its address
//   rs1_data_i, rs2_data_i  register-file read data
//   out_valid_o/out_ready_i downstream handshake
//   a_o, b_o, op_o          ALU operands and operation code
//   pc_o, rd_o              pc and destination of the dispatched instruction
//   wb_en_o                 result is written back (never for rd == x0)
//   branch_o, invert_o      conditional branch; invert_o means taken on 0
//   illegal_o               unsupported encoding (still handshaken through)
//
// Optional feature (macro ALU_DISPATCH_PERF_EN):
//   perf_issued_o           count of downstream transfers
//   perf_stall_o            count of cycles with output held by backpressure
module alu_dispatch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [3:0]  op_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rd_o,
  output logic        wb_en_o,
  output logic        branch_o,
  output logic        invert_o,
  output logic        illegal_o
`ifdef ALU_DISPATCH_PERF_EN
  ,
  output logic [31:0] perf_issued_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_LT   = 4'd3;
  localparam logic [3:0] ALU_LTU  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_GTE  = 4'd11;
  localparam logic [3:0] ALU_GTEU = 4'd12;
  localparam logic [3:0] ALU_JALR = 4'd13;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
    logic        inv;
    logic        ill;
  } ent_t;

  // funct3 -> ALU op for OP / OP-IMM (SUB/SRA selected separately by funct7)
  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_LT;
      3'b011:  return ALU_LTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic ent_t rst_ent();
    ent_t e;
    e    = '0;
    e.op = ALU_ADD;
    e.pc = RESET_PC;
    return e;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic signed [31:0] imm_i, imm_s, imm_u, imm_j;
  logic legal;
  ent_t dec;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                  instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec    = '0;
    dec.pc = pc_i;
    dec.rd = instr_i[11:7];
    dec.op = ALU_ADD;
    legal  = 1'b1;
    case (opc)
      7'b0110011: begin
        dec.a  = rs1_data_i;
        dec.b  = rs2_data_i;
        dec.wb = 1'b1;
        if (f7 == 7'b0000000)                    dec.op = f3_op(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000) dec.op = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) dec.op = ALU_SRA;
        else                                     legal  = 1'b0;
      end
      7'b0010011: begin
        dec.a  = rs1_data_i;
        dec.wb = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // shifts take shamt only; funct7 shares the immediate's top bits
          dec.b  = {27'b0, instr_i[24:20]};
          dec.op = f3_op(f3);
          if (f3 == 3'b101 && f7 == 7'b0100000) dec.op = ALU_SRA;
          else if (f7 != 7'b0000000)            legal  = 1'b0;
        end else begin
          dec.b  = imm_i;
          dec.op = f3_op(f3);
        end
      end
      7'b0110111: begin
        dec.b  = imm_u;
        dec.wb = 1'b1;
      end
      7'b0010111: begin
        dec.a  = pc_i;
        dec.b  = imm_u;
        dec.wb = 1'b1;
      end
      7'b1101111: begin
        dec.a  = pc_i;
        dec.b  = imm_j;
        dec.wb = 1'b1;
      end
      7'b1100111: begin
        dec.a  = rs1_data_i;
        dec.b  = imm_i;
        dec.op = ALU_JALR;
        dec.wb = 1'b1;
        legal  = (f3 == 3'b000);
      end
      7'b1100011: begin
        dec.a  = rs1_data_i;
        dec.b  = rs2_data_i;
        dec.br = 1'b1;
        case (f3)
          3'b000:  dec.op = ALU_EQ;
          3'b001:  begin dec.op = ALU_EQ; dec.inv = 1'b1; end
          3'b100:  dec.op = ALU_LT;
          3'b101:  dec.op = ALU_GTE;
          3'b110:  dec.op = ALU_LTU;
          3'b111:  dec.op = ALU_GTEU;
          default: legal  = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec.a  = rs1_data_i;
        dec.b  = imm_i;
        dec.wb = 1'b1;
      end
      7'b0100011: begin
        dec.a = rs1_data_i;
        dec.b = imm_s;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.a   = '0;
      dec.b   = '0;
      dec.op  = ALU_ADD;
      dec.wb  = 1'b0;
      dec.br  = 1'b0;
      dec.inv = 1'b0;
      dec.ill = 1'b1;
    end
    if (dec.rd == 5'd0) dec.wb = 1'b0;
  end

  ent_t out_q, out_d, skid_q, skid_d;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, in_rdy_q, in_rdy_d;
  logic accept, out_free;

  assign accept   = in_valid_i & in_rdy_q;
  assign out_free = ~out_vld_q | out_ready_i;

  // in_rdy_q is set whenever the skid will be empty, so an accept never
  // coincides with a full skid; the skid always drains ahead of new input.
  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q      <= rst_ent();
      skid_q     <= rst_ent();
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready_o  = in_rdy_q;
  assign out_valid_o = out_vld_q;
  assign a_o         = out_q.a;
  assign b_o         = out_q.b;
  assign op_o        = out_q.op;
  assign pc_o        = out_q.pc;
  assign rd_o        = out_q.rd;
  assign wb_en_o     = out_q.wb;
  assign branch_o    = out_q.br;
  assign invert_o    = out_q.inv;
  assign illegal_o   = out_q.ill;

`ifdef ALU_DISPATCH_PERF_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (out_vld_q & out_ready_i)  issued_q <= issued_q + 32'd1;
      if (out_vld_q & ~out_ready_i) stall_q  <= stall_q + 32'd1;
    end
  end

  assign perf_issued_o = issued_q;
  assign perf_stall_o  = stall_q;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;

  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLL = 2, ALU_LT = 3, ALU_LTU = 4,
                 ALU_XOR = 5, ALU_SRL = 6, ALU_SRA = 7, ALU_OR = 8, ALU_AND = 9,
                 ALU_EQ = 10, ALU_GTE = 11, ALU_GTEU = 12, ALU_JALR = 13;
  localparam int F3OP [8] = '{ALU_ADD, ALU_SLL, ALU_LT, ALU_LTU,
                              ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                                      7'h67, 7'h63, 7'h03, 7'h23};

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1, rs2, a, b, pc_out;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic        wb_en, branch, invert, illegal;
`ifdef ALU_DISPATCH_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  alu_dispatch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .a_o(a), .b_o(b), .op_o(op), .pc_o(pc_out), .rd_o(rd),
    .wb_en_o(wb_en), .branch_o(branch), .invert_o(invert), .illegal_o(illegal)
`ifdef ALU_DISPATCH_PERF_EN
    , .perf_issued_o(perf_issued), .perf_stall_o(perf_stall)
`endif
  );

  typedef struct {
    logic [31:0] a, b, pc;
    int          op, rd;
    bit          wb, br, inv, ill;
  } exp_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decoder written straight from the instruction-set rules.
  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] ipc,
                                     input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    bit ok;
    int f3, f7;
    logic [31:0] ii, si, ui, ji;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    ii = {{20{ins[31]}}, ins[31:20]};
    si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ui = {ins[31:12], 12'h000};
    ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e.pc = ipc; e.rd = int'(ins[11:7]);
    e.a = 0; e.b = 0; e.op = ALU_ADD; e.wb = 0; e.br = 0; e.inv = 0; e.ill = 0;
    ok = 1;
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; e.wb = 1;
        if (f7 == 0) e.op = F3OP[f3];
        else if (f7 == 32 && f3 == 0) e.op = ALU_SUB;
        else if (f7 == 32 && f3 == 5) e.op = ALU_SRA;
        else ok = 0;
      end
      7'h13: begin
        e.a = r1; e.wb = 1; e.op = F3OP[f3];
        if (f3 == 1 || f3 == 5) begin
          e.b = {27'h0, ins[24:20]};
          if (f3 == 5 && f7 == 32) e.op = ALU_SRA;
          else if (f7 != 0) ok = 0;
        end else e.b = ii;
      end
      7'h37: begin e.b = ui; e.wb = 1; end
      7'h17: begin e.a = ipc; e.b = ui; e.wb = 1; end
      7'h6F: begin e.a = ipc; e.b = ji; e.wb = 1; end
      7'h67: begin e.a = r1; e.b = ii; e.op = ALU_JALR; e.wb = 1; ok = (f3 == 0); end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1;
        case (f3)
          0: e.op = ALU_EQ;
          1: begin e.op = ALU_EQ; e.inv = 1; end
          4: e.op = ALU_LT;
          5: e.op = ALU_GTE;
          6: e.op = ALU_LTU;
          7: e.op = ALU_GTEU;
          default: ok = 0;
        endcase
      end
      7'h03: begin e.a = r1; e.b = ii; e.wb = 1; end
      7'h23: begin e.a = r1; e.b = si; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.a = 0; e.b = 0; e.op = ALU_ADD; e.wb = 0; e.br = 0; e.inv = 0; e.ill = 1;
    end
    if (e.rd == 0) e.wb = 0;
    return e;
  endfunction

  // Scoreboard: queue of instructions inside the stage, oldest first.
  exp_t        q[$];
  logic [31:0] xfer_pc[$];
  int          xfer_cyc[$];
  int          cyc = 0;
  longint      m_issued = 0, m_stall = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_issued = 0; m_stall = 0;
    end
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (out_valid && q.size() > 0) begin
      chk("a", a, q[0].a);
      chk("b", b, q[0].b);
      chk("op", 32'(op), q[0].op);
      chk("pc", pc_out, q[0].pc);
      chk("rd", 32'(rd), q[0].rd);
      chk("wb_en", 32'(wb_en), 32'(q[0].wb));
      chk("branch", 32'(branch), 32'(q[0].br));
      chk("invert", 32'(invert), 32'(q[0].inv));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
`ifdef ALU_DISPATCH_PERF_EN
    chk("perf_issued", perf_issued, 32'(m_issued));
    chk("perf_stall", perf_stall, 32'(m_stall));
`endif
    // predict the effect of the coming rising edge (inputs are stable now)
    if (rst_n) begin
      if (out_valid && out_ready) m_issued++;
      if (out_valid && !out_ready) m_stall++;
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() > 0) begin
          xfer_pc.push_back(q[0].pc);
          xfer_cyc.push_back(cyc);
          void'(q.pop_front());
        end
        if (in_valid && in_ready) q.push_back(model_dec(instr, pc, rs1, rs2));
      end
    end
  end

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input logic [31:0] ins, input logic [31:0] ipc,
                      input logic [31:0] r1, input logic [31:0] r2);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1; instr = ins; pc = ipc; rs1 = r1; rs2 = r2;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got no accept want accept pc=%h", ipc);
    end
    #1 in_valid = 0;
  endtask

  exp_t e;
  int   base;

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    instr = 0; pc = 0; rs1 = 0; rs2 = 0;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op", 32'(op), ALU_ADD);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_a", a, 32'h0);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    rst_n = 1;

    // pin the reference decoder itself
    e = model_dec(32'h40B50533, 0, 7, 3);
    chk("m_sub_op", e.op, ALU_SUB);
    chk("m_sub_rd", e.rd, 10);
    e = model_dec(32'hFFF00093, 0, 0, 0);
    chk("m_addi_b", e.b, 32'hFFFF_FFFF);
    e = model_dec(32'h00209463, 0, 0, 0);
    chk("m_bne_inv", 32'(e.inv), 1);

    send(32'h40B50533, 32'h10, 7, 3);
    @(negedge clk);
    chk("sub_vld", 32'(out_valid), 1);
    chk("sub_a", a, 7);
    chk("sub_b", b, 3);
    chk("sub_op", 32'(op), ALU_SUB);
    chk("sub_rd", 32'(rd), 10);
    chk("sub_wb", 32'(wb_en), 1);

    send(32'hFFF00093, 32'h14, 0, 0);
    @(negedge clk);
    chk("addi_b", b, 32'hFFFF_FFFF);
    chk("addi_op", 32'(op), ALU_ADD);

    send(32'h00209463, 32'h18, 5, 6);
    @(negedge clk);
    chk("bne_op", 32'(op), ALU_EQ);
    chk("bne_br", 32'(branch), 1);
    chk("bne_inv", 32'(invert), 1);
    chk("bne_wb", 32'(wb_en), 0);

    send(32'h0000007F, 32'h1C, 9, 9);
    @(negedge clk);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_wb", 32'(wb_en), 0);
    chk("ill_a", a, 0);

    // backpressure: three back-to-back, out_ready low
    @(posedge clk); #1 out_ready = 0;
    base = xfer_pc.size();
    send(32'h00100093, 32'h100, 1, 1);
    send(32'h00200113, 32'h104, 2, 2);
    in_valid = 1; instr = 32'h00300193; pc = 32'h108; rs1 = 3; rs2 = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rdy", 32'(in_ready), 0);
      chk("bp_hold_pc", pc_out, 32'h100);
    end
    @(posedge clk); #1 out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1 in_valid = 0;
    repeat (3) @(negedge clk);
    chk("bp_count", xfer_pc.size() - base, 3);
    if (xfer_pc.size() - base == 3) begin
      chk("bp_ord0", xfer_pc[base], 32'h100);
      chk("bp_ord1", xfer_pc[base + 1], 32'h104);
      chk("bp_ord2", xfer_pc[base + 2], 32'h108);
      chk("bp_consec", xfer_cyc[base + 2] - xfer_cyc[base], 2);
    end

    // flush with the skid full and the next instruction offered
    @(posedge clk); #1 out_ready = 0;
    send(32'h00400213, 32'h200, 0, 0);
    send(32'h00500293, 32'h204, 0, 0);
    in_valid = 1; instr = 32'h00600313; pc = 32'h208; flush = 1;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("fl1_vld", 32'(out_valid), 0);
    chk("fl1_rdy", 32'(in_ready), 1);

    // flush coinciding with a real accept: the accepted one is dropped
    send(32'h00700393, 32'h300, 0, 0);
    in_valid = 1; instr = 32'h00800413; pc = 32'h304; flush = 1;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("fl2_vld", 32'(out_valid), 0);
    chk("fl2_rdy", 32'(in_ready), 1);
    @(negedge clk);
    chk("fl2_drop", 32'(out_valid), 0);

    // asynchronous reset with entries pending
    send(32'h00900493, 32'h400, 0, 0);
    send(32'h00A00513, 32'h404, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_vld", 32'(out_valid), 0);
    chk("arst_rdy", 32'(in_ready), 1);
    chk("arst_op", 32'(op), ALU_ADD);
    @(posedge clk); #1 rst_n = 1; out_ready = 1;

    // randomized traffic checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(39) == 0);
      instr     = $urandom;
      if ($urandom_range(7) != 0) instr[6:0] = OPCS[$urandom_range(8)];
      pc  = $urandom & 32'hFFFF_FFFC;
      rs1 = $urandom;
      rs2 = $urandom;
    end
    @(posedge clk); #1 in_valid = 0; flush = 0; out_ready = 1;
    repeat (5) @(negedge clk);
    chk("drain_vld", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
